// File: rtl/dram_arb_pkg.sv
// Shared port ids and default widths for the two-port DRAM command arbiter.
package dram_arb_pkg;

  localparam int unsigned PORT_IFETCH = 0;
  localparam int unsigned PORT_LSU    = 1;

  localparam int unsigned DEF_ADDR_WIDTH     = 27;
  localparam int unsigned DEF_DATA_WIDTH     = 128;
  localparam int unsigned DEF_MASK_WIDTH     = 16;
  localparam int unsigned DEF_TAG_ADDR_WIDTH = 3;

  localparam int unsigned MAX_OUTSTANDING = 2 ** DEF_TAG_ADDR_WIDTH;

endpackage

// File: rtl/SyncFIFO.sv
// Synchronous show-ahead FIFO of depth 2**ADDR_WIDTH; head word is visible on o_data.
module SyncFIFO #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;

  // Extra pointer msb distinguishes full from empty.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign o_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (i_wr && !o_full)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_rd && !o_empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr && !o_full) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_data;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin two-port arbiter in front of the DRAM wrapper's user command interface.
// Define DRAM_ARB_PERF_EN to add grant and stall performance counters.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned MASK_WIDTH     = DEF_MASK_WIDTH,
  parameter int unsigned TAG_ADDR_WIDTH = DEF_TAG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_m0_ren,
  input  logic                  i_m0_wen,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  input  logic [MASK_WIDTH-1:0] i_m0_mask,
  output logic                  o_m0_ack,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  output logic                  o_m0_data_valid,
  input  logic                  i_m1_ren,
  input  logic                  i_m1_wen,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  input  logic [MASK_WIDTH-1:0] i_m1_mask,
  output logic                  o_m1_ack,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  output logic                  o_m1_data_valid,
  output logic                  o_dram_ren,
  output logic                  o_dram_wen,
  output logic [ADDR_WIDTH-1:0] o_dram_addr,
  output logic [DATA_WIDTH-1:0] o_dram_data,
  output logic [MASK_WIDTH-1:0] o_dram_mask,
  output logic                  o_dram_busy,
  input  logic                  i_dram_busy,
  input  logic [DATA_WIDTH-1:0] i_dram_data,
  input  logic                  i_dram_data_valid,
`ifdef DRAM_ARB_PERF_EN
  output logic [31:0]           o_m0_grants,
  output logic [31:0]           o_m1_grants,
  output logic [31:0]           o_stall_cycles,
`endif
  output logic                  o_err
);

  localparam int unsigned CntW = TAG_ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] MaxOut = {1'b1, {TAG_ADDR_WIDTH{1'b0}}};

  logic            last_grant_q;
  logic [CntW-1:0] outstanding_q;
  logic            err_q, m0_dv_q, m1_dv_q;
  logic [DATA_WIDTH-1:0] m0_data_q, m1_data_q;

  logic room, elig0, elig1, grant, gnt_port, sel_lsu;
  logic issue_rd, ret_ok, ret_err, head_port, fifo_full, fifo_empty;

  assign room     = (outstanding_q < MaxOut) && !fifo_full;
  assign elig0    = i_m0_wen || (i_m0_ren && room);
  assign elig1    = i_m1_wen || (i_m1_ren && room);
  assign grant    = i_rst_n && !i_dram_busy && (elig0 || elig1);
  assign gnt_port = (elig0 && elig1) ? !last_grant_q : elig1;
  assign sel_lsu  = grant && (gnt_port == 1'(PORT_LSU));

  always_comb begin
    o_m0_ack    = grant && !sel_lsu;
    o_m1_ack    = sel_lsu;
    o_dram_ren  = 1'b0;
    o_dram_wen  = 1'b0;
    o_dram_addr = sel_lsu ? i_m1_addr : i_m0_addr;
    o_dram_data = sel_lsu ? i_m1_data : i_m0_data;
    o_dram_mask = sel_lsu ? i_m1_mask : i_m0_mask;
    // A request with both strobes high is a write.
    if (grant) begin
      o_dram_wen = sel_lsu ? i_m1_wen : i_m0_wen;
      o_dram_ren = sel_lsu ? (i_m1_ren && !i_m1_wen) : (i_m0_ren && !i_m0_wen);
    end
    if (!i_rst_n) begin
      o_dram_addr = '0;
      o_dram_data = '0;
      o_dram_mask = '0;
    end
  end

  assign o_dram_busy = 1'b0;
  assign issue_rd    = o_dram_ren;
  assign ret_ok      = i_dram_data_valid && (outstanding_q != '0) && !fifo_empty;
  assign ret_err     = i_dram_data_valid && (outstanding_q == '0);

  SyncFIFO #(
    .DATA_WIDTH (1),
    .ADDR_WIDTH (TAG_ADDR_WIDTH)
  ) u_tag_fifo (
    .clk     (clk),
    .i_rst   (!i_rst_n),
    .i_wr    (issue_rd),
    .i_data  (gnt_port),
    .i_rd    (ret_ok),
    .o_data  (head_port),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      last_grant_q  <= 1'b1;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      m0_dv_q       <= 1'b0;
      m1_dv_q       <= 1'b0;
      m0_data_q     <= '0;
      m1_data_q     <= '0;
    end else begin
      if (issue_rd && !ret_ok)      outstanding_q <= outstanding_q + 1'b1;
      else if (!issue_rd && ret_ok) outstanding_q <= outstanding_q - 1'b1;
      if (grant)   last_grant_q <= gnt_port;
      if (ret_err) err_q <= 1'b1;
      m0_dv_q <= ret_ok && !head_port;
      m1_dv_q <= ret_ok && head_port;
      if (ret_ok && !head_port) m0_data_q <= i_dram_data;
      if (ret_ok && head_port)  m1_data_q <= i_dram_data;
    end
  end

  assign o_m0_data_valid = m0_dv_q;
  assign o_m1_data_valid = m1_dv_q;
  assign o_m0_data       = m0_data_q;
  assign o_m1_data       = m1_data_q;
  assign o_err           = err_q;

`ifdef DRAM_ARB_PERF_EN
  logic [31:0] m0_grants_q, m1_grants_q, stall_q;
  logic        any_req;

  assign any_req = i_m0_ren || i_m0_wen || i_m1_ren || i_m1_wen;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      m0_grants_q <= '0;
      m1_grants_q <= '0;
      stall_q     <= '0;
    end else begin
      if (o_m0_ack) m0_grants_q <= m0_grants_q + 32'd1;
      if (o_m1_ack) m1_grants_q <= m1_grants_q + 32'd1;
      if (any_req && !grant) stall_q <= stall_q + 32'd1;
    end
  end

  assign o_m0_grants    = m0_grants_q;
  assign o_m1_grants    = m1_grants_q;
  assign o_stall_cycles = stall_q;
`endif

endmodule
